// File: rtl/dpath_gen.sv
// Parametrised accumulator datapath with encoded bus mux and request/ready memory access FSM.
// Optional wait-state timeout enabled by defining MEM_TIMEOUT_EN.
module dpath_gen #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned NREG        = 4,
    parameter int unsigned TIMEOUT_CYC = 15,
    localparam int unsigned RSEL_W     = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        bus_src,
    input  logic [RSEL_W-1:0] rsel,
    input  logic              ld_ar,
    input  logic              inc_ar,
    input  logic              ld_pc,
    input  logic              inc_pc,
    input  logic              ld_dr,
    input  logic              ld_ir,
    input  logic              ld_tr,
    input  logic              ld_r,
    input  logic              ld_ac,
    input  logic              ld_acbus,
    input  logic              ld_flags,
    input  logic [3:0]        alus,
    input  logic              mem_rd,
    input  logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_req,
    output logic              mem_we,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] ir_q,
    output logic [DATA_W-1:0] ac_q,
    output logic              z,
    output logic              c,
    output logic              n
);

    localparam int unsigned DW1 = DATA_W + 1;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] ar_q, pc_q;
    logic [DATA_W-1:0] dr_q, tr_q, wdata_q, wdata_d;
    logic [DATA_W-1:0] rf_q [NREG];
    logic              done_d, err_d, rd_cpl_c;
    logic [ADDR_W-1:0] bus_c;
    logic [DATA_W-1:0] bus_lo_c, rf_rd_c, alu_res_c;
    logic              alu_cy_c;

    assign mem_addr  = ar_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q != ST_IDLE);
    assign mem_req   = busy;
    assign mem_we    = (state_q == ST_WR);

    // Register-file read port; indices beyond NREG read as zero
    always_comb begin
        rf_rd_c = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            if (rsel == RSEL_W'(i)) rf_rd_c = rf_q[i];
        end
    end

    // Encoded bus source mux
    always_comb begin
        case (bus_src)
            3'd1:    bus_c = pc_q;
            3'd2:    bus_c = ADDR_W'(dr_q);
            3'd3:    bus_c = {dr_q[ADDR_W-DATA_W-1:0], tr_q};
            3'd4:    bus_c = ADDR_W'(rf_rd_c);
            3'd5:    bus_c = ADDR_W'(ac_q);
            3'd6:    bus_c = ADDR_W'(tr_q);
            3'd7:    bus_c = ADDR_W'(ir_q);
            default: bus_c = '0;
        endcase
    end
    assign bus_lo_c = bus_c[DATA_W-1:0];

    // ALU: AC op bus, carry/borrow computed one bit wider
    always_comb begin
        alu_res_c = ac_q;
        alu_cy_c  = 1'b0;
        case (alus)
            4'd0:  alu_res_c = bus_lo_c;
            4'd1:  {alu_cy_c, alu_res_c} = DW1'(ac_q) + DW1'(bus_lo_c);
            4'd2:  {alu_cy_c, alu_res_c} = DW1'(ac_q) - DW1'(bus_lo_c);
            4'd3:  {alu_cy_c, alu_res_c} = DW1'(ac_q) + DW1'(1);
            4'd4:  alu_res_c = ac_q & bus_lo_c;
            4'd5:  alu_res_c = ac_q | bus_lo_c;
            4'd6:  alu_res_c = ac_q ^ bus_lo_c;
            4'd7:  alu_res_c = ~ac_q;
            4'd8:  {alu_cy_c, alu_res_c} = {ac_q, 1'b0};
            4'd9:  {alu_res_c, alu_cy_c} = {1'b0, ac_q};
            4'd10: alu_res_c = '0;
            default: alu_res_c = ac_q;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned WCNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [WCNT_W-1:0] wait_q, wait_d;
`else
    logic unused_timeout_c;
    assign unused_timeout_c = ^TIMEOUT_CYC;
`endif

    // Access FSM next state
    always_comb begin
        state_d  = state_q;
        done_d   = 1'b0;
        err_d    = err;
        wdata_d  = wdata_q;
        rd_cpl_c = 1'b0;
`ifdef MEM_TIMEOUT_EN
        wait_d   = '0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (mem_rd) begin
                    state_d = ST_RD;
                    if (mem_wr) err_d = 1'b1;
                end else if (mem_wr) begin
                    state_d = ST_WR;
                    wdata_d = dr_q;
                end
            end
            ST_RD, ST_WR: begin
                if (mem_ready) begin
                    state_d  = ST_IDLE;
                    done_d   = 1'b1;
                    rd_cpl_c = (state_q == ST_RD);
`ifdef MEM_TIMEOUT_EN
                end else if (wait_q == WCNT_W'(TIMEOUT_CYC - 1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    wait_d = wait_q + WCNT_W'(1);
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            done    <= 1'b0;
            err     <= 1'b0;
            wdata_q <= '0;
`ifdef MEM_TIMEOUT_EN
            wait_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            done    <= done_d;
            err     <= err_d;
            wdata_q <= wdata_d;
`ifdef MEM_TIMEOUT_EN
            wait_q  <= wait_d;
`endif
        end
    end

    // Datapath registers; all controller strobes are frozen while an access is pending
    always_ff @(posedge clk) begin
        if (rst) begin
            ar_q <= '0;
            pc_q <= '0;
            dr_q <= '0;
            tr_q <= '0;
            ir_q <= '0;
            ac_q <= '0;
            z    <= 1'b0;
            c    <= 1'b0;
            n    <= 1'b0;
            for (int unsigned i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else if (!busy) begin
            if (ld_ar)       ar_q <= bus_c;
            else if (inc_ar) ar_q <= ar_q + ADDR_W'(1);
            if (ld_pc)       pc_q <= bus_c;
            else if (inc_pc) pc_q <= pc_q + ADDR_W'(1);
            if (ld_dr) dr_q <= bus_lo_c;
            if (ld_ir) ir_q <= dr_q;
            if (ld_tr) tr_q <= dr_q;
            if (ld_r) begin
                for (int unsigned i = 0; i < NREG; i++) begin
                    if (rsel == RSEL_W'(i)) rf_q[i] <= bus_lo_c;
                end
            end
            if (ld_ac)         ac_q <= alu_res_c;
            else if (ld_acbus) ac_q <= bus_lo_c;
            if (ld_flags) begin
                z <= (alu_res_c == '0);
                n <= alu_res_c[DATA_W-1];
                c <= alu_cy_c;
            end
        end else if (rd_cpl_c) begin
            dr_q <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_dpath_gen.sv
// Self-checking bench for dpath_gen: directed literal checks plus randomized run against a behavioural model.
// Define MEM_TIMEOUT_EN for both bench and RTL to exercise the timeout path.
module tb_dpath_gen;

    localparam int DMASK = 255;
    localparam int AMASK = 65535;
    localparam int TO    = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] bus_src;
    logic [1:0] rsel;
    logic       ld_ar, inc_ar, ld_pc, inc_pc, ld_dr, ld_ir, ld_tr, ld_r, ld_ac, ld_acbus, ld_flags;
    logic [3:0] alus;
    logic       mem_rd, mem_wr, mem_ready;
    logic [7:0] mem_rdata;
    logic [15:0] mem_addr;
    logic [7:0] mem_wdata, ir_q, ac_q;
    logic       mem_req, mem_we, busy, done, err, z, c, n;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 0;

    dpath_gen dut (
        .clk(clk), .rst(rst), .bus_src(bus_src), .rsel(rsel),
        .ld_ar(ld_ar), .inc_ar(inc_ar), .ld_pc(ld_pc), .inc_pc(inc_pc),
        .ld_dr(ld_dr), .ld_ir(ld_ir), .ld_tr(ld_tr), .ld_r(ld_r),
        .ld_ac(ld_ac), .ld_acbus(ld_acbus), .ld_flags(ld_flags), .alus(alus),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .err(err), .ir_q(ir_q), .ac_q(ac_q),
        .z(z), .c(c), .n(n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: architectural registers plus a pending-access descriptor
    int m_ar, m_pc, m_dr, m_ir, m_tr, m_ac, m_wdata, m_kind, m_wait;
    int m_r [4];
    int m_z, m_c, m_n, m_err, m_done;

    function automatic int bus_m();
        case (int'(bus_src))
            1: return m_pc;
            2: return m_dr;
            3: return ((m_dr << 8) | m_tr) & AMASK;
            4: return m_r[rsel];
            5: return m_ac;
            6: return m_tr;
            7: return m_ir;
            default: return 0;
        endcase
    endfunction

    function automatic void alu_m(input int a, input int b, input int op, output int r, output int cy);
        cy = 0;
        case (op)
            0: r = b;
            1: begin r = a + b; cy = (r > DMASK) ? 1 : 0; end
            2: begin r = a - b; cy = (a < b) ? 1 : 0; end
            3: begin r = a + 1; cy = (r > DMASK) ? 1 : 0; end
            4: r = a & b;
            5: r = a | b;
            6: r = a ^ b;
            7: r = DMASK - a;
            8: begin r = a * 2; cy = (r > DMASK) ? 1 : 0; end
            9: begin r = a / 2; cy = a % 2; end
            10: r = 0;
            default: r = a;
        endcase
        r = r & DMASK;
    endfunction

    always @(posedge clk) begin
        int bus, blo, res, cy, odr;
        if (rst) begin
            m_ar = 0; m_pc = 0; m_dr = 0; m_ir = 0; m_tr = 0; m_ac = 0; m_wdata = 0;
            m_kind = 0; m_wait = 0; m_z = 0; m_c = 0; m_n = 0; m_err = 0; m_done = 0;
            for (int i = 0; i < 4; i++) m_r[i] = 0;
        end else begin
            bus = bus_m();
            blo = bus & DMASK;
            alu_m(m_ac, blo, int'(alus), res, cy);
            odr = m_dr;
            m_done = 0;
            if (m_kind == 0) begin
                if (ld_ar) m_ar = bus; else if (inc_ar) m_ar = (m_ar + 1) & AMASK;
                if (ld_pc) m_pc = bus; else if (inc_pc) m_pc = (m_pc + 1) & AMASK;
                if (ld_dr) m_dr = blo;
                if (ld_ir) m_ir = odr;
                if (ld_tr) m_tr = odr;
                if (ld_r) m_r[rsel] = blo;
                if (ld_ac) m_ac = res; else if (ld_acbus) m_ac = blo;
                if (ld_flags) begin
                    m_z = (res == 0) ? 1 : 0;
                    m_n = (res >= 128) ? 1 : 0;
                    m_c = cy;
                end
                if (mem_rd) begin
                    m_kind = 1; m_wait = 0;
                    if (mem_wr) m_err = 1;
                end else if (mem_wr) begin
                    m_kind = 2; m_wait = 0; m_wdata = odr;
                end
            end else if (mem_ready) begin
                if (m_kind == 1) m_dr = int'(mem_rdata);
                m_kind = 0;
                m_done = 1;
            end else begin
                m_wait++;
`ifdef MEM_TIMEOUT_EN
                if (m_wait >= TO) begin
                    m_kind = 0; m_done = 1; m_err = 1;
                end
`endif
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("mem_addr", 32'(mem_addr), m_ar);
            chk("mem_wdata", 32'(mem_wdata), m_wdata);
            chk("mem_req", 32'(mem_req), (m_kind != 0) ? 1 : 0);
            chk("mem_we", 32'(mem_we), (m_kind == 2) ? 1 : 0);
            chk("busy", 32'(busy), (m_kind != 0) ? 1 : 0);
            chk("done", 32'(done), m_done);
            chk("err", 32'(err), m_err);
            chk("ir_q", 32'(ir_q), m_ir);
            chk("ac_q", 32'(ac_q), m_ac);
            chk("z", 32'(z), m_z);
            chk("c", 32'(c), m_c);
            chk("n", 32'(n), m_n);
        end
    end

    task automatic idle();
        {ld_ar, inc_ar, ld_pc, inc_pc, ld_dr, ld_ir, ld_tr, ld_r, ld_ac, ld_acbus, ld_flags} = '0;
        bus_src = 3'd0; rsel = 2'd0; alus = 4'd0;
        mem_rd = 1'b0; mem_wr = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic nxt();
        @(negedge clk);
        idle();
    endtask

    task automatic mem_read(input logic [7:0] val);
        mem_rd = 1'b1; nxt();
        mem_ready = 1'b1; mem_rdata = val; nxt();
    endtask

    initial begin
        int reqs;
        idle();
        mem_rdata = 8'h00;
        rst = 1'b1;
        @(negedge clk); @(negedge clk);
        chk_en = 1'b1;
        rst = 1'b0;
        chk("rst_addr", 32'(mem_addr), 32'h0);
        chk("rst_req", 32'(mem_req), 32'h0);
        chk("rst_err", 32'(err), 32'h0);

        // PC load/increment/wrap
        bus_src = 3'd1; ld_ar = 1'b1; nxt();
        chk("ar_from_pc0", 32'(mem_addr), 32'h0000);
        repeat (3) begin inc_pc = 1'b1; nxt(); end
        bus_src = 3'd1; ld_ar = 1'b1; nxt();
        chk("pc_inc3", 32'(mem_addr), 32'h0003);
        alus = 4'd7; ld_ac = 1'b1; nxt();
        chk("ac_not0", 32'(ac_q), 32'hFF);
        bus_src = 3'd5; ld_dr = 1'b1; nxt();
        ld_tr = 1'b1; nxt();
        bus_src = 3'd3; ld_pc = 1'b1; nxt();
        bus_src = 3'd1; ld_ar = 1'b1; nxt();
        chk("pc_ffff", 32'(mem_addr), 32'hFFFF);
        inc_pc = 1'b1; nxt();
        bus_src = 3'd1; ld_ar = 1'b1; nxt();
        chk("pc_wrap", 32'(mem_addr), 32'h0000);

        // {DR,TR} bus composition, load beats increment
        mem_read(8'h34);
        ld_tr = 1'b1; nxt();
        mem_read(8'h12);
        bus_src = 3'd3; ld_pc = 1'b1; nxt();
        bus_src = 3'd1; ld_ar = 1'b1; inc_ar = 1'b1; nxt();
        chk("ar_ld_beats_inc", 32'(mem_addr), 32'h1234);

        // Read with two wait states
        mem_rd = 1'b1; nxt();
        reqs = 0;
        for (int i = 0; i < 3; i++) begin
            if (mem_req) reqs++;
            mem_ready = (i == 2); mem_rdata = 8'h5A; nxt();
        end
        chk("req_cycles", reqs, 3);
        chk("done_pulse", 32'(done), 32'h1);
        chk("busy_after", 32'(busy), 32'h0);
        bus_src = 3'd2; ld_acbus = 1'b1; nxt();
        chk("done_clear", 32'(done), 32'h0);
        chk("dr_read", 32'(ac_q), 32'h5A);

        // ALU add and sub with flags
        mem_read(8'hF0);
        bus_src = 3'd2; ld_acbus = 1'b1; nxt();
        mem_read(8'h20);
        bus_src = 3'd2; ld_r = 1'b1; rsel = 2'd1; nxt();
        bus_src = 3'd4; rsel = 2'd1; alus = 4'd1; ld_ac = 1'b1; ld_flags = 1'b1; nxt();
        chk("add_ac", 32'(ac_q), 32'h10);
        chk("add_flags", {29'd0, z, c, n}, 32'b010);
        bus_src = 3'd5; ld_r = 1'b1; rsel = 2'd2; nxt();
        bus_src = 3'd4; rsel = 2'd2; alus = 4'd2; ld_ac = 1'b1; ld_flags = 1'b1; nxt();
        chk("sub_ac", 32'(ac_q), 32'h00);
        chk("sub_flags", {29'd0, z, c, n}, 32'b100);

        // Write with stalled controller strobes
        mem_read(8'h77);
        mem_wr = 1'b1; nxt();
        chk("wr_we", 32'(mem_we), 32'h1);
        chk("wr_wdata", 32'(mem_wdata), 32'h77);
        repeat (2) begin alus = 4'd7; ld_ac = 1'b1; ld_dr = 1'b1; bus_src = 3'd5; nxt(); end
        mem_ready = 1'b1; nxt();
        chk("wr_stall_ac", 32'(ac_q), 32'h00);
        bus_src = 3'd2; ld_acbus = 1'b1; nxt();
        chk("wr_stall_dr", 32'(ac_q), 32'h77);

        // Simultaneous read and write request
        mem_rd = 1'b1; mem_wr = 1'b1; nxt();
        chk("both_err", 32'(err), 32'h1);
        chk("both_we", 32'(mem_we), 32'h0);
        mem_ready = 1'b1; mem_rdata = 8'h3C; nxt();
        bus_src = 3'd2; ld_acbus = 1'b1; nxt();
        chk("both_read", 32'(ac_q), 32'h3C);

`ifdef MEM_TIMEOUT_EN
        mem_read(8'h99);
        mem_rd = 1'b1; nxt();
        repeat (TO - 1) nxt();
        chk("to_not_yet", 32'(done), 32'h0);
        nxt();
        chk("to_done", 32'(done), 32'h1);
        chk("to_err", 32'(err), 32'h1);
        bus_src = 3'd2; ld_acbus = 1'b1; nxt();
        chk("to_dr_kept", 32'(ac_q), 32'h99);
`endif

        // Reset in the middle of an access
        mem_rd = 1'b1; nxt();
        rst = 1'b1; nxt();
        rst = 1'b0;
        chk("rst_mid_req", 32'(mem_req), 32'h0);
        chk("rst_mid_ac", 32'(ac_q), 32'h0);
        chk("rst_mid_err", 32'(err), 32'h0);

        // Randomized run
        for (int k = 0; k < 3000; k++) begin
            rst      = ($urandom_range(0, 299) == 0);
            bus_src  = 3'($urandom_range(0, 7));
            rsel     = 2'($urandom_range(0, 3));
            alus     = 4'($urandom_range(0, 15));
            ld_ar    = ($urandom_range(0, 3) == 0);
            inc_ar   = ($urandom_range(0, 3) == 0);
            ld_pc    = ($urandom_range(0, 3) == 0);
            inc_pc   = ($urandom_range(0, 3) == 0);
            ld_dr    = ($urandom_range(0, 3) == 0);
            ld_ir    = ($urandom_range(0, 3) == 0);
            ld_tr    = ($urandom_range(0, 3) == 0);
            ld_r     = ($urandom_range(0, 2) == 0);
            ld_ac    = ($urandom_range(0, 2) == 0);
            ld_acbus = ($urandom_range(0, 2) == 0);
            ld_flags = ($urandom_range(0, 2) == 0);
            mem_rd   = ($urandom_range(0, 5) == 0);
            mem_wr   = ($urandom_range(0, 5) == 0);
            mem_ready = ($urandom_range(0, 2) == 0);
            mem_rdata = 8'($urandom);
            @(negedge clk);
        end
        rst = 1'b0;
        idle();
        @(negedge clk);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dpath_gen.md
Name: dpath_gen

Overview:
- Parametrised successor to the fixed 8-bit accumulator datapath. Contains AR, PC, DR, IR, TR, AC, an NREG-entry general register file and Z/C/N flags.
- The tri-state internal bus is replaced by an encoded source mux.
- Adds a request/ready memory handshake FSM with stall (busy) so the controller tolerates wait-state memory.
- Sits between the microprogrammed/hardwired controller and external memory.

Parameters:
DATA_W, 8, data/register width
ADDR_W, 16, address/PC/AR width; legal range DATA_W < ADDR_W <= 2*DATA_W
NREG, 4, general registers R0..R(NREG-1); RSEL_W = max(1, clog2(NREG)) derived
TIMEOUT_CYC, 15, wait-cycle limit (used only with MEM_TIMEOUT_EN)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous reset, active-high
bus_src  in  3  bus source: 0 none(0), 1 PC, 2 DR, 3 {DR,TR}, 4 R[rsel], 5 AC, 6 TR, 7 IR
rsel  in  RSEL_W  register file index
ld_ar, inc_ar, ld_pc, inc_pc  in  1 each  address register controls
ld_dr, ld_ir, ld_tr, ld_r, ld_ac, ld_acbus, ld_flags  in  1 each  load strobes
alus  in  4  ALU operation
mem_rd, mem_wr  in  1 each  start memory read/write (single-cycle pulse)
mem_addr  out  ADDR_W  = AR
mem_wdata  out  DATA_W  write data, held during access
mem_req  out  1  access pending
mem_we  out  1  1 = write access
mem_ready  in  1  memory completes access this cycle
mem_rdata  in  DATA_W  read data, valid with mem_ready
busy  out  1  access FSM not IDLE
done  out  1  one-cycle pulse on access completion
err  out  1  sticky error flag
ir_q, ac_q  out  DATA_W  IR and AC contents
z, c, n  out  1 each  flags

Behaviour:
- Reset (rst=1 at edge): all registers, flags, err, done = 0; FSM to IDLE; mem_req/mem_we = 0 from the next cycle. This applies mid-access: the transaction is abandoned.
- Bus is combinational, ADDR_W wide, unused upper bits 0:
  - Source 2/5/6/7 zero-extended.
  - Source 3 = DR in bits [ADDR_W-1:DATA_W] (truncated), TR in the low bits.
  - R[rsel] with rsel >= NREG reads 0.
- Register loads:
  - DATA_W registers load bus[DATA_W-1:0]; AR/PC load the full bus.
  - DR→IR and DR→TR load directly from DR, not the bus.
  - Load beats inc on the same cycle. AR/PC inc wraps modulo 2^ADDR_W.
  - ld_r with rsel >= NREG is ignored.
  - ld_ac loads the ALU result; ld_acbus loads the bus; ld_ac wins if both are asserted.
- ALU (combinational, AC op bus low):
  - 0 pass bus, 1 add, 2 sub AC-bus, 3 inc AC, 4 and, 5 or, 6 xor, 7 not AC, 8 shl AC, 9 shr AC (logical), 10 zero, 11-15 pass AC.
  - C: add/inc carry-out; sub borrow (1 iff AC < bus unsigned); shl shifted-out MSB; shr shifted-out LSB; others 0.
  - On ld_flags: z = (result == 0), n = result MSB, C as above. Flags are independent of ld_ac.
- Access FSM, states IDLE, RD, WR:
  - IDLE + mem_rd → RD. IDLE + mem_wr → WR, capturing DR into mem_wdata.
  - Both mem_rd and mem_wr in IDLE: read taken, err set.
  - RD/WR: mem_req = 1, mem_we = (state == WR).
  - Edge with mem_ready = 1: RD writes mem_rdata into DR; FSM returns to IDLE and done = 1 for one cycle.
  - Minimum access: request cycle + 1 (memory ready in the first RD/WR cycle) → done 2 cycles after the mem_rd edge.
- Stall: while busy, every ld_*/inc_* and further mem_rd/mem_wr is ignored. The bus stays combinational.
- mem_ready while IDLE is ignored.

Optional Feature:
MEM_TIMEOUT_EN:
- Defined: a wait counter counts cycles in RD/WR. If it reaches TIMEOUT_CYC without mem_ready, the FSM returns to IDLE, DR is unchanged, err is set, done = 1, and the counter clears.
- Undefined: no counter; the FSM waits indefinitely.

Test Plan:
- Reset, then bus_src=1, ld_ar=1 with PC=0 → AR=0x0000. inc_pc ×3 → PC=0x0003. PC=0xFFFF + inc_pc → PC=0x0000.
- AR=0x1234, mem_rd pulse, mem_ready asserted 3 cycles later with mem_rdata=0x5A → mem_req high 3 cycles, DR=0x5A, done one pulse, busy low after.
- DR=0x12, TR=0x34, bus_src=3, ld_pc → PC=0x1234. ld_ar+inc_ar same cycle → AR=bus value, no increment.
- AC=0xF0, R1=0x20 via bus_src=4/rsel=1, alus=1, ld_ac, ld_flags → AC=0x10, c=1, z=0, n=0. Then alus=2 with bus 0x10 → AC=0x00, z=1, c=0.
- mem_wr while DR=0x77, ld_ac asserted during the wait → mem_wdata=0x77, AC unchanged. mem_rd+mem_wr together → read performed, err=1.
- MEM_TIMEOUT_EN, mem_rd, mem_ready never asserted → done and err at wait cycle 15, DR unchanged. Separately, rst mid-access → mem_req=0 next cycle, all registers 0.
